mul_acc_stage: RTL

Operand-staging and accumulation stage wrapped around the team's WIDTH-parameterised combinational Dadda multiplier. It accepts operand pairs over a valid/ready handshake and registers them into the multiplier's `if_multiplier` inputs. It captures the 2·WIDTH product and accumulates LEN products into one dot-product result. The result is emitted over a second valid/ready handshake to downstream consumers.

---
 rtl/mul_acc_pkg.sv | 20 ++
 rtl/if_multiplier.sv | 12 +
 rtl/dadda_mul.sv | 12 +
 rtl/mul_acc_add.sv | 23 ++
 rtl/mul_acc_stage.sv | 146 ++++++++++++++
 5 files changed

// File: rtl/mul_acc_pkg.sv
// Shared types and default widths for the multiply-accumulate stage.
package mul_acc_pkg;

  localparam int DEF_WIDTH     = 6;
  localparam int DEF_LEN       = 4;
  localparam int DEF_ACC_WIDTH = 14;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } mac_state_t;

  // The full product of two w-bit unsigned operands needs 2*w bits.
  function automatic int acc_width_min(input int w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/if_multiplier.sv
// Operand/product bundle between the staging logic and the multiplier.
interface if_multiplier #(
  parameter int WIDTH = 6
) ();
  logic [WIDTH-1:0]   in1;
  logic [WIDTH-1:0]   in2;
  logic [2*WIDTH-1:0] out;
  logic               overflow;

  modport mul   (input in1, input in2, output out, output overflow);
  modport stage (output in1, output in2, input out, input overflow);
endinterface

// File: rtl/dadda_mul.sv
// WIDTH x WIDTH unsigned combinational multiplier behind if_multiplier.
// overflow flags a product that does not fit back into WIDTH bits.
module dadda_mul #(
  parameter int WIDTH = 6
) (
  if_multiplier.mul muif
);
  localparam int PW = 2 * WIDTH;

  assign muif.out      = PW'(muif.in1) * PW'(muif.in2);
  assign muif.overflow = |muif.out[PW-1:WIDTH];
endmodule

// File: rtl/mul_acc_add.sv
// Accumulator adder: acc + addend at ACC_WIDTH+1 bits; carry is the overflow.
// MUL_ACC_SAT_EN defined  : sum clamps to all-ones on carry.
// MUL_ACC_SAT_EN undefined: sum wraps modulo 2^ACC_WIDTH.
module mul_acc_add #(
  parameter int ACC_WIDTH = 14
) (
  input  logic [ACC_WIDTH-1:0] acc,
  input  logic [ACC_WIDTH-1:0] addend,
  output logic [ACC_WIDTH-1:0] sum,
  output logic                 carry
);
  logic [ACC_WIDTH:0] full;

  assign full  = {1'b0, acc} + {1'b0, addend};
  assign carry = full[ACC_WIDTH];

`ifdef MUL_ACC_SAT_EN
  // Once clamped, further nonzero terms carry again, so the sum stays at max.
  assign sum = carry ? {ACC_WIDTH{1'b1}} : full[ACC_WIDTH-1:0];
`else
  assign sum = full[ACC_WIDTH-1:0];
`endif
endmodule

// File: rtl/mul_acc_stage.sv
// Operand staging + multiply + accumulate of LEN products into one result.
// Pipeline: S1 operand regs -> multiplier -> S2 product reg -> S3 accumulator.
// Build option: MUL_ACC_SAT_EN selects a saturating accumulator (see mul_acc_add).
//
// state | meaning
// IDLE  | acc/cnt cleared, waiting for the first pair of a batch
// ACCUM | taking pairs until LEN have been accepted
// DRAIN | all pairs accepted, waiting for the last product to be added
// DONE  | result presented on out_acc/out_ovf until taken
module mul_acc_stage
  import mul_acc_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int LEN       = DEF_LEN,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_acc,
  output logic                 out_ovf
);
  localparam int PROD_W = acc_width_min(WIDTH);
  localparam int CNT_W  = $clog2(LEN + 1);
  localparam logic [CNT_W-1:0] LEN_C = CNT_W'(LEN);

  mac_state_t             state, state_nxt;
  logic                   in_ready_q;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_inc;
  logic                   s1_valid;
  logic [WIDTH-1:0]       s1_a, s1_b;
  logic                   s2_valid;
  logic [ACC_WIDTH-1:0]   s2_prod;
  logic [ACC_WIDTH-1:0]   acc;
  logic                   ovf;
  logic [ACC_WIDTH-1:0]   add_sum;
  logic                   add_carry;
  logic                   accept;
  logic                   final_add;
  logic                   take;
  logic [PROD_W-1:0]      prod;
  logic                   unused_mul_ovf;

  if_multiplier #(.WIDTH(WIDTH)) muif ();

  dadda_mul #(.WIDTH(WIDTH)) u_mul (.muif(muif));

  assign muif.in1       = s1_a;
  assign muif.in2       = s1_b;
  assign prod           = muif.out;
  // The multiplier's own overflow has no meaning here: the full product is kept.
  assign unused_mul_ovf = muif.overflow;

  mul_acc_add #(.ACC_WIDTH(ACC_WIDTH)) u_add (
    .acc    (acc),
    .addend (s2_prod),
    .sum    (add_sum),
    .carry  (add_carry)
  );

  assign accept    = in_valid & in_ready_q;
  assign cnt_inc   = cnt + 1'b1;
  assign final_add = (state == DRAIN) & s2_valid & ~s1_valid;
  assign take      = (state == DONE) & out_ready;

  assign in_ready  = in_ready_q;
  assign out_valid = (state == DONE);
  assign out_acc   = acc;
  assign out_ovf   = ovf;

  // Next-state decode; clr overrides every handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (cnt_inc == LEN_C) ? DRAIN : ACCUM;
      ACCUM:   if (accept && (cnt_inc == LEN_C)) state_nxt = DRAIN;
      DRAIN:   if (final_add) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (clr) state_nxt = IDLE;
  end

  // State register; in_ready is registered from the next state so it never
  // depends combinationally on in_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      in_ready_q <= 1'b1;
    end else begin
      state      <= state_nxt;
      in_ready_q <= (state_nxt == IDLE) || (state_nxt == ACCUM);
    end
  end

  // Term counter: accepted pairs in the current batch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              cnt <= '0;
    else if (clr || take) cnt <= '0;
    else if (accept)      cnt <= cnt_inc;
  end

  // S1 operand and S2 product registers with their valid bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s2_valid <= 1'b0;
      s2_prod  <= '0;
    end else if (clr) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_a <= in_a;
        s1_b <= in_b;
      end
      s2_valid <= s1_valid;
      if (s1_valid) s2_prod <= ACC_WIDTH'(prod);
    end
  end

  // S3 accumulator with sticky overflow; cleared on abort or result handoff.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (clr || take) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (s2_valid) begin
      acc <= add_sum;
      ovf <= ovf | add_carry;
    end
  end

endmodule
